ddr_app_responder: RTL and testbench
====================================

Name: ddr_app_responder

Overview:
- Synthesizable BRAM-backed stand-in for the DDR3 memory-interface IP, seen from its user (app) port.
- Answers the command/write-data/read-data handshake that the traffic generator drives.
- Lets the test bench and test pattern logic run on-chip or in simulation with no DDR3 device or PHY present.
- Sits where the DDR3 IP instance sits; the generator connects unchanged.

Parameters:
ADDR_WIDTH, 29, width of the app address (rank+bank+row+column)
APP_DATA_WIDTH, 256, data beat width (one BL8 burst of 32-bit DQ)
APP_MASK_WIDTH, 32, byte-mask width (APP_DATA_WIDTH/8)
DEPTH_LOG2, 10, log2 of emulated beats in BRAM
INIT_CYCLES, 1000, clocks from reset release to init_calib_complete
RD_LATENCY, 8, clocks from read acceptance to rd_data_valid (>=2)
REF_CYCLES, 16, clocks cmd_ready held low for a refresh
WDF_DEPTH, 4, write-data FIFO entries (power of two)

Ports:
clk  in  1  user clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_en  in  1  command valid
cmd  in  3  3'b000 write, 3'b001 read; other codes accepted and ignored
addr  in  ADDR_WIDTH  beat address; addr[DEPTH_LOG2+2:3] indexes BRAM, upper bits and addr[2:0] ignored
cmd_ready  out  1  command accepted when cmd_en && cmd_ready
wr_data  in  APP_DATA_WIDTH  write beat
wr_data_en  in  1  beat valid
wr_data_end  in  1  last beat of burst; always 1 with wr_data_en (one beat per command)
wr_data_mask  in  APP_MASK_WIDTH  bit=1 leaves that byte unwritten
wr_data_rdy  out  1  beat accepted when wr_data_en && wr_data_rdy
rd_data  out  APP_DATA_WIDTH  read beat
rd_data_valid  out  1  rd_data valid, one cycle per read
rd_data_end  out  1  equals rd_data_valid
sr_req  in  1  self-refresh request (level)
ref_req  in  1  user refresh request (pulse)
sr_ack  out  1  high while in self-refresh
ref_ack  out  1  one-cycle pulse at refresh end
init_calib_complete  out  1  ready indicator

Behaviour:
- Reset values: cmd_ready=0, wr_data_rdy=0, rd_data=0, rd_data_valid=0, rd_data_end=0, sr_ack=0, ref_ack=0, init_calib_complete=0.
- Reset clears FSM, FIFO pointers, read pipeline, counters. BRAM contents are not cleared.
- Reset mid-operation drops in-flight reads: no rd_data_valid after rst_n deasserts until a new read is accepted.
- FSM states:
  - INIT: count INIT_CYCLES, then go to IDLE and set init_calib_complete=1 (sticky until reset).
  - IDLE: cmd_ready=1. Accepted read goes into the read pipeline; stay in IDLE. Accepted write with FIFO non-empty pops the FIFO and writes BRAM in the same cycle; stay in IDLE. Accepted write with FIFO empty latches addr and goes to WR_WAIT.
  - WR_WAIT: cmd_ready=0. On first FIFO entry (including a same-cycle push, bypass allowed), write BRAM, then go to IDLE.
  - REFRESH: cmd_ready=0 for REF_CYCLES, pulse ref_ack on the last cycle, then go to IDLE.
  - SELFREF: cmd_ready=0 and sr_ack=1 while sr_req=1; go to IDLE the cycle after sr_req falls.
- Refresh/self-refresh entry only from IDLE with no command accepted that cycle.
- Priority when both pending: ref_req over sr_req. A ref_req pulse arriving in WR_WAIT is latched and serviced on return to IDLE.
- In-flight reads still complete during REFRESH/SELFREF.
- cmd_ready and wr_data_rdy never depend combinationally on cmd_en or wr_data_en.
- wr_data_rdy = init_calib_complete && FIFO not full. Beats may arrive up to WDF_DEPTH ahead of their commands.
- Writes: byte-masked BRAM write; byte i written iff wr_data_mask[i]==0.
- Reads: BRAM read issued on acceptance; result delayed through a shift pipeline to exactly RD_LATENCY cycles. Back-to-back reads give back-to-back valids, in order.
- Read-after-write to the same address, in command order, returns the new data. Commands are serialized, so no hazard logic is needed beyond BRAM read-during-write = new-data or a one-cycle forward.
- Address wrap: index bits beyond DEPTH_LOG2 are ignored, so aliasing is intentional.
- FIFO full: wr_data_rdy=0; beats offered while full are not taken. FIFO empty with a write command: handled by WR_WAIT.

Decomposition:
- Package ddr_app_pkg holds:
  - CMD_WRITE=3'b000, CMD_READ=3'b001
  - FSM state enum {INIT, IDLE, WR_WAIT, REFRESH, SELFREF}
  - Default widths 29/256/32
- Sub-module ddr_app_wdf_fifo: synchronous FIFO, WDF_DEPTH x (APP_DATA_WIDTH+APP_MASK_WIDTH), push/pop/full/empty, same clock/reset.

Test Plan:
- Reset release, INIT_CYCLES=1000 -> init_calib_complete and cmd_ready rise on cycle 1000 ±0; wr_data_rdy rises with it.
- Write addr 0x08 data 0xA5 repeated, mask 0, then read 0x08 -> rd_data=0xA5..A5 exactly 8 cycles after read acceptance, rd_data_end with it.
- Write 0xFF..FF, then write 0x00..00 with mask 0xFFFFFFFE, read -> byte0=0x00, all other bytes 0xFF.
- Push 4 beats with no command -> wr_data_rdy low after 4th; then write cmd with empty FIFO enters WR_WAIT, cmd_ready=0 until a beat arrives.
- 16 back-to-back reads -> 16 consecutive valid cycles, in address order; ref_req mid-stream -> cmd_ready low 16 cycles, one ref_ack pulse, pending reads still delivered.
- Assert rst_n low with 3 reads in flight -> no rd_data_valid afterward; BRAM data intact on later read.

Source files
------------

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the DDR3 app-port responder.
// Holds the command encodings, the controller state type and the default
// port widths used by ddr_app_responder and its write-data FIFO.
package ddr_app_pkg;

    localparam int DEF_ADDR_WIDTH     = 29;
    localparam int DEF_APP_DATA_WIDTH = 256;
    localparam int DEF_APP_MASK_WIDTH = 32;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_WAIT,
        REFRESH,
        SELFREF
    } state_e;

endpackage

// File: rtl/ddr_app_wdf_fifo.sv
// Write-data FIFO: holds {mask, data} beats that arrive ahead of their
// write commands. Show-ahead output (pop_data is the head entry).
// Ports: clk/rst_n, push + push_data, pop, pop_data, full, empty.
// Callers must not push when full or pop when empty. DEPTH is a power of
// two, at least 2.
module ddr_app_wdf_fifo
    import ddr_app_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_APP_DATA_WIDTH + DEF_APP_MASK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ddr_app_responder.sv
// BRAM-backed stand-in for a DDR3 memory controller's user (app) port.
// Ports: clk/rst_n; command channel cmd_en/cmd/addr/cmd_ready; write data
// wr_data/wr_data_en/wr_data_end/wr_data_mask/wr_data_rdy; read data
// rd_data/rd_data_valid/rd_data_end; maintenance sr_req/ref_req with
// sr_ack/ref_ack; init_calib_complete.
// One command per cycle, one beat per command. Reads return after exactly
// RD_LATENCY clocks, in order, and keep flowing through refresh.
module ddr_app_responder
    import ddr_app_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int APP_DATA_WIDTH = DEF_APP_DATA_WIDTH,
    parameter int APP_MASK_WIDTH = DEF_APP_MASK_WIDTH,
    parameter int DEPTH_LOG2     = 10,
    parameter int INIT_CYCLES    = 1000,
    parameter int RD_LATENCY     = 8,
    parameter int REF_CYCLES     = 16,
    parameter int WDF_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_en,
    input  logic [2:0]                cmd,
    input  logic [ADDR_WIDTH-1:0]     addr,
    output logic                      cmd_ready,
    input  logic [APP_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_data_en,
    input  logic                      wr_data_end,
    input  logic [APP_MASK_WIDTH-1:0] wr_data_mask,
    output logic                      wr_data_rdy,
    output logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_data_valid,
    output logic                      rd_data_end,
    input  logic                      sr_req,
    input  logic                      ref_req,
    output logic                      sr_ack,
    output logic                      ref_ack,
    output logic                      init_calib_complete
);

    localparam int FW  = APP_DATA_WIDTH + APP_MASK_WIDTH;
    localparam int ICW = $clog2(INIT_CYCLES + 1);
    localparam int RCW = $clog2(REF_CYCLES + 1);

    state_e                    state, state_nx;
    logic [ICW-1:0]            init_cnt;
    logic [RCW-1:0]            ref_cnt;
    logic                      init_done, ref_pend;
    logic [DEPTH_LOG2-1:0]     cmd_idx, wr_idx_q, we_idx;
    logic                      cmd_acc, beat_acc, rd_acc;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]             fifo_out;
    logic                      mem_we;
    logic [APP_DATA_WIDTH-1:0] we_data;
    logic [APP_MASK_WIDTH-1:0] we_mask;
    logic [APP_DATA_WIDTH-1:0] mem [1 << DEPTH_LOG2];
    logic [APP_DATA_WIDTH-1:0] rd_q;
    logic [RD_LATENCY:1]       vld_pipe;
    logic [RD_LATENCY:2][APP_DATA_WIDTH-1:0] dat_pipe;
    logic                      unused_ok;

    // Bank/row bits above the BRAM index alias on purpose; column bits and
    // wr_data_end carry no information for single-beat bursts.
    assign unused_ok = ^{wr_data_end, addr[ADDR_WIDTH-1:DEPTH_LOG2+3], addr[2:0]};

    // Handshake outputs come from state only, never from the valids.
    assign cmd_ready   = (state == IDLE);
    assign wr_data_rdy = init_done && !fifo_full;
    assign sr_ack      = (state == SELFREF);
    assign init_calib_complete = init_done;

    assign cmd_acc  = cmd_en && cmd_ready;
    assign beat_acc = wr_data_en && wr_data_rdy;
    assign cmd_idx  = addr[DEPTH_LOG2+2:3];

    ddr_app_wdf_fifo #(.DEPTH(WDF_DEPTH), .WIDTH(FW)) u_wdf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({wr_data_mask, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nx  = state;
        fifo_push = beat_acc;
        fifo_pop  = 1'b0;
        mem_we    = 1'b0;
        we_idx    = cmd_idx;
        we_data   = fifo_out[APP_DATA_WIDTH-1:0];
        we_mask   = fifo_out[FW-1:APP_DATA_WIDTH];
        rd_acc    = 1'b0;
        ref_ack   = 1'b0;
        case (state)
            INIT: if (init_cnt == ICW'(INIT_CYCLES - 1)) state_nx = IDLE;
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd == CMD_READ) begin
                        rd_acc = 1'b1;
                    end else if (cmd == CMD_WRITE) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            mem_we   = 1'b1;
                        end else begin
                            state_nx = WR_WAIT;
                        end
                    end
                end else if (ref_pend || ref_req) begin
                    state_nx = REFRESH;
                end else if (sr_req) begin
                    state_nx = SELFREF;
                end
            end
            WR_WAIT: begin
                we_idx = wr_idx_q;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mem_we   = 1'b1;
                    state_nx = IDLE;
                end else if (beat_acc) begin
                    // Beat goes straight to BRAM instead of through the FIFO.
                    fifo_push = 1'b0;
                    mem_we    = 1'b1;
                    we_data   = wr_data;
                    we_mask   = wr_data_mask;
                    state_nx  = IDLE;
                end
            end
            REFRESH: begin
                if (ref_cnt == RCW'(REF_CYCLES - 1)) begin
                    ref_ack  = 1'b1;
                    state_nx = IDLE;
                end
            end
            SELFREF: if (!sr_req) state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            ref_cnt   <= '0;
            init_done <= 1'b0;
            ref_pend  <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (state == INIT && state_nx == IDLE) init_done <= 1'b1;
            ref_cnt <= (state == REFRESH) ? ref_cnt + 1'b1 : '0;
            // A refresh request that cannot be honoured now waits here.
            if (state == IDLE && state_nx == REFRESH) ref_pend <= 1'b0;
            else if (ref_req && init_done)             ref_pend <= 1'b1;
            if (cmd_acc) wr_idx_q <= cmd_idx;
        end
    end

    // BRAM: byte-masked write, registered read. Commands are serialized, so
    // a read always lands at least one edge after the write it depends on.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!we_mask[b]) mem[we_idx][b*8 +: 8] <= we_data[b*8 +: 8];
            end
        end
        if (rd_acc) rd_q <= mem[cmd_idx];
    end

    // rd_q is pipeline stage 1; the rest pad the latency to RD_LATENCY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[2] <= rd_q;
            for (int i = 3; i <= RD_LATENCY; i++) dat_pipe[i] <= dat_pipe[i-1];
        end
    end

    assign rd_data       = dat_pipe[RD_LATENCY];
    assign rd_data_valid = vld_pipe[RD_LATENCY];
    assign rd_data_end   = vld_pipe[RD_LATENCY];

endmodule

// File: tb/tb_ddr_app_responder.sv
module tb_ddr_app_responder;

    localparam int DW    = 256;
    localparam int MW    = 32;
    localparam int AW    = 29;
    localparam int LAT   = 8;
    localparam int INITC = 1000;

    logic          clk, rst_n;
    logic          cmd_en, cmd_ready;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_data_en, wr_data_end, wr_data_rdy;
    logic [MW-1:0] wr_data_mask;
    logic          rd_data_valid, rd_data_end;
    logic          sr_req, ref_req, sr_ack, ref_ack, init_calib_complete;

    ddr_app_responder dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_en(cmd_en), .cmd(cmd), .addr(addr), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
        .wr_data_mask(wr_data_mask), .wr_data_rdy(wr_data_rdy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
        .sr_req(sr_req), .ref_req(ref_req), .sr_ack(sr_ack), .ref_ack(ref_ack),
        .init_calib_complete(init_calib_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
    exp_t sb[$];

    typedef struct {
        bit            do_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt[9];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every valid beat must match the head entry, in data and cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rd_data_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rd_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_latency_cycle", cyc, e.cyc);
                chk("rd_data_end", rd_data_end, 1);
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] m);
        int n = 0;
        wr_data = d; wr_data_mask = m; wr_data_en = 1'b1; wr_data_end = 1'b1;
        while (!wr_data_rdy && n < 200) begin @(posedge clk); #1; n++; end
        if (!wr_data_rdy) chk("beat_timeout", 0, 1);
        @(posedge clk); #1;
        wr_data_en = 1'b0; wr_data_end = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        exp_t e;
        cmd_en = 1'b1; cmd = c; addr = a;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) chk("cmd_timeout", 0, 1);
        if (c == 3'b001) begin
            e.data = d; e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Counts cmd_ready-low cycles and ref_ack pulses over a 30-cycle window.
    task automatic check_refresh(input string name, input bit pulse);
        int lows = 0, acks = 0, ack_low = 0;
        if (pulse) begin
            ref_req = 1'b1; @(posedge clk); #1; ref_req = 1'b0;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!cmd_ready) lows++;
            if (ref_ack) begin acks++; if (!cmd_ready) ack_low++; end
        end
        #1;
        chk({name, "_low_cycles"}, lows, 16);
        chk({name, "_ack_pulses"}, acks, 1);
        chk({name, "_ack_in_refresh"}, ack_low, 1);
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] base, input int i);
        logic [31:0] w;
        w = base + 32'(i);
        return {8{w}};
    endfunction

    initial begin
        vt[0] = '{1'b1, 29'h08,        {32{8'hA5}},          32'h0,         {32{8'hA5}}};
        vt[1] = '{1'b1, 29'h10,        {DW{1'b1}},           32'h0,         {DW{1'b1}}};
        vt[2] = '{1'b1, 29'h10,        {DW{1'b0}},           32'hFFFF_FFFE, {{31{8'hFF}}, 8'h00}};
        vt[3] = '{1'b1, 29'h18,        {8{32'hDEADBEEF}},    32'h0,         {8{32'hDEADBEEF}}};
        vt[4] = '{1'b1, 29'h18,        {8{32'h01234567}},    32'hFFFF_0000, {{4{32'hDEADBEEF}}, {4{32'h01234567}}}};
        vt[5] = '{1'b1, 29'h2008,      {32{8'h5A}},          32'h0,         {32{8'h5A}}};
        vt[6] = '{1'b0, 29'h08,        {DW{1'b0}},           32'h0,         {32{8'h5A}}};
        vt[7] = '{1'b0, 29'h0F,        {DW{1'b0}},           32'h0,         {32{8'h5A}}};
        vt[8] = '{1'b0, 29'h1000_0010, {DW{1'b0}},           32'h0,         {{31{8'hFF}}, 8'h00}};

        rst_n = 1'b0; cmd_en = 1'b0; cmd = 3'b0; addr = '0;
        wr_data = '0; wr_data_en = 1'b0; wr_data_end = 1'b0; wr_data_mask = '0;
        sr_req = 1'b0; ref_req = 1'b0;

        repeat (3) @(posedge clk); #1;
        chk("reset_ctl", {cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end, sr_ack, ref_ack, init_calib_complete}, 0);
        chk("reset_rd_data", rd_data, 0);

        // Init: ready flags rise on exactly the INITC-th edge after release.
        @(negedge clk); rst_n = 1'b1;
        repeat (INITC - 1) @(posedge clk); #1;
        chk("init_early", {init_calib_complete, cmd_ready, wr_data_rdy}, 3'b000);
        @(posedge clk); #1;
        chk("init_done", {init_calib_complete, cmd_ready, wr_data_rdy}, 3'b111);

        // Table: write (beat ahead of command) then read back.
        foreach (vt[i]) begin
            if (vt[i].do_wr) begin
                send_beat(vt[i].wdata, vt[i].mask);
                issue(3'b000, vt[i].addr, '0);
            end
            issue(3'b001, vt[i].addr, vt[i].exp);
        end
        drain();

        // Fill the FIFO with no commands, offer extra beats while full.
        for (int i = 0; i < 4; i++) begin
            send_beat(pat(32'hC0DE0000, i), '0);
            if (i == 2) chk("fifo_not_full_3", wr_data_rdy, 1);
        end
        chk("fifo_full_rdy", wr_data_rdy, 0);
        wr_data = {DW{1'b1}}; wr_data_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        wr_data_en = 1'b0;
        chk("fifo_still_full", wr_data_rdy, 0);
        for (int i = 0; i < 4; i++) issue(3'b000, 29'h100 + 29'(i * 8), '0);

        // Write with empty FIFO waits; a ref_req arriving meanwhile is held.
        issue(3'b000, 29'h200, '0);
        for (int i = 0; i < 3; i++) begin
            chk("wr_wait_ready_low", cmd_ready, 0);
            if (i == 1) ref_req = 1'b1;
            @(posedge clk); #1;
            ref_req = 1'b0;
        end
        send_beat({8{32'h600DF00D}}, '0);
        chk("wr_wait_exit", cmd_ready, 1);
        check_refresh("ref_latched", 1'b0);
        for (int i = 0; i < 4; i++) issue(3'b001, 29'h100 + 29'(i * 8), pat(32'hC0DE0000, i));
        issue(3'b001, 29'h200, {8{32'h600DF00D}});
        drain();

        // Sixteen back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            send_beat(pat(32'hB0000000, i), '0);
            issue(3'b000, 29'h300 + 29'(i * 8), '0);
        end
        for (int i = 0; i < 16; i++) issue(3'b001, 29'h300 + 29'(i * 8), pat(32'hB0000000, i));
        drain();

        // Refresh with reads in flight; those reads must still arrive.
        for (int i = 0; i < 4; i++) issue(3'b001, 29'h300 + 29'(i * 8), pat(32'hB0000000, i));
        check_refresh("ref_midstream", 1'b1);
        for (int i = 4; i < 16; i++) issue(3'b001, 29'h300 + 29'(i * 8), pat(32'hB0000000, i));
        drain();

        // Self-refresh entry/exit.
        sr_req = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("sr_active", {sr_ack, cmd_ready}, 2'b10);
        sr_req = 1'b0;
        @(posedge clk); #1;
        chk("sr_exit", {sr_ack, cmd_ready}, 2'b01);

        // Refresh wins over self-refresh when both are requested.
        sr_req = 1'b1; ref_req = 1'b1;
        @(posedge clk); #1;
        ref_req = 1'b0;
        chk("ref_over_sr", {sr_ack, cmd_ready}, 2'b00);
        repeat (20) @(posedge clk); #1;
        chk("sr_after_ref", sr_ack, 1);
        sr_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset with three reads in flight: they must never appear.
        for (int i = 0; i < 3; i++) issue(3'b001, 29'h08, {32{8'h5A}});
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_ctl", {cmd_ready, wr_data_rdy, rd_data_valid, init_calib_complete}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        begin
            int n = 0;
            while (!init_calib_complete && n < INITC + 50) begin @(posedge clk); n++; end
        end
        #1;
        chk("reinit_done", init_calib_complete, 1);
        issue(3'b001, 29'h2008, {32{8'h5A}});
        issue(3'b001, 29'h18, {{4{32'hDEADBEEF}}, {4{32'h01234567}}});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
